// File: rtl/router_reg_param.sv
// Packet register stage between the router FSM and the output FIFOs.
// Holds the header, stages payload bytes, and checks integrity and payload length.
module router_reg_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 2,
   parameter int CHK_MODE = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pkt_valid,
   input  logic [DATA_W-1:0]        din,
   input  logic                     fifo_full,
   input  logic                     detect_addr,
   input  logic                     ld_state,
   input  logic                     laf_state,
   input  logic                     full_state,
   input  logic                     lfd_state,
   input  logic                     rst_int_reg,
   output logic [DATA_W-1:0]        dout,
   output logic                     err,
   output logic                     len_err,
   output logic                     parity_done,
   output logic                     low_pkt_valid,
   output logic [DATA_W-ADDR_W-1:0] pay_cnt
);

   localparam int LEN_W = DATA_W - ADDR_W;

   // Handshake: there is no ready. The source presents one byte per cycle with
   // pkt_valid high for the header and payload; the single cycle with pkt_valid
   // low while the FSM is loading carries the packet check byte. Back-pressure
   // is signalled to the FSM (fifo_full) and absorbed by hold_reg.

   logic [DATA_W-1:0] hdr_reg;
   logic [DATA_W-1:0] hold_reg;
   logic [DATA_W-1:0] chk_int;
   logic [DATA_W-1:0] chk_pkt;
   logic              chk_eval;

   logic addr_ok;
   logic hdr_ld;
   logic pay_acc;
   logic chk_ld;
   logic pd_set;

   function automatic logic [DATA_W-1:0] chk_fold(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] b);
      if (CHK_MODE == 1) return acc + b;
      else               return acc ^ b;
   endfunction

   always_comb begin
      addr_ok = (din[ADDR_W-1:0] != {ADDR_W{1'b1}});
      hdr_ld  = detect_addr && pkt_valid && addr_ok;
      pay_acc = ld_state && pkt_valid && !full_state;
      chk_ld  = ld_state && !pkt_valid;
      pd_set  = (chk_ld && !fifo_full) || (laf_state && low_pkt_valid && !parity_done);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hdr_reg <= '0;
      end else if (hdr_ld) begin
         hdr_reg <= din;
      end
   end

   // Output byte path: header first, then live payload, then the held byte.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dout     <= '0;
         hold_reg <= '0;
      end else if (lfd_state) begin
         dout <= hdr_reg;
      end else if (ld_state && !fifo_full) begin
         dout <= din;
      end else if (ld_state && fifo_full) begin
         hold_reg <= din;
      end else if (laf_state) begin
         dout <= hold_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         chk_int <= '0;
      end else if (detect_addr) begin
         chk_int <= '0;
      end else if (lfd_state) begin
         chk_int <= chk_fold(chk_int, hdr_reg);
      end else if (pay_acc) begin
         chk_int <= chk_fold(chk_int, din);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pay_cnt <= '0;
      end else if (detect_addr) begin
         pay_cnt <= '0;
      end else if (pay_acc && (pay_cnt != {LEN_W{1'b1}})) begin
         pay_cnt <= pay_cnt + LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         chk_pkt <= '0;
      end else if (chk_ld) begin
         chk_pkt <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         low_pkt_valid <= 1'b0;
      end else if (rst_int_reg) begin
         low_pkt_valid <= 1'b0;
      end else if (chk_ld) begin
         low_pkt_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         parity_done <= 1'b0;
      end else if (detect_addr) begin
         parity_done <= 1'b0;
      end else if (pd_set) begin
         parity_done <= 1'b1;
      end
   end

   // Verdict is taken once, the edge after parity_done rises, then held.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err      <= 1'b0;
         len_err  <= 1'b0;
         chk_eval <= 1'b0;
      end else if (detect_addr) begin
         err      <= 1'b0;
         len_err  <= 1'b0;
         chk_eval <= 1'b0;
      end else if (parity_done && !chk_eval) begin
         err      <= (chk_int != chk_pkt);
         len_err  <= (pay_cnt != hdr_reg[DATA_W-1:ADDR_W]);
         chk_eval <= 1'b1;
      end
   end

endmodule

// File: tb/tb_router_reg_param.sv
// Directed bench for router_reg_param: XOR-parity and sum-checksum instances
// driven in lockstep with hand-computed expected values.
module tb_router_reg_param;

   logic       clk;
   logic       rst;
   logic       pkt_valid;
   logic [7:0] din;
   logic       fifo_full;
   logic       detect_addr;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       lfd_state;
   logic       rst_int_reg;

   logic [7:0] dout,   dout_s;
   logic       err,    err_s;
   logic       len_err, len_err_s;
   logic       parity_done, parity_done_s;
   logic       low_pkt_valid, low_pkt_valid_s;
   logic [5:0] pay_cnt, pay_cnt_s;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] pay [0:4];

   router_reg_param #(.DATA_W(8), .ADDR_W(2), .CHK_MODE(0)) u_xor (
      .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
      .detect_addr(detect_addr), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .lfd_state(lfd_state), .rst_int_reg(rst_int_reg),
      .dout(dout), .err(err), .len_err(len_err), .parity_done(parity_done),
      .low_pkt_valid(low_pkt_valid), .pay_cnt(pay_cnt)
   );

   router_reg_param #(.DATA_W(8), .ADDR_W(2), .CHK_MODE(1)) u_sum (
      .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
      .detect_addr(detect_addr), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .lfd_state(lfd_state), .rst_int_reg(rst_int_reg),
      .dout(dout_s), .err(err_s), .len_err(len_err_s), .parity_done(parity_done_s),
      .low_pkt_valid(low_pkt_valid_s), .pay_cnt(pay_cnt_s)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard: expected dout bytes in order
   task automatic check_dout(input string tag);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s expected queue empty", tag);
      end else begin
         e = exp_q.pop_front();
         check_eq(tag, {8'h00, dout}, {8'h00, e});
      end
   endtask

   // driver tasks
   task automatic clr_ctl();
      pkt_valid   = 1'b0;
      din         = 8'h00;
      fifo_full   = 1'b0;
      detect_addr = 1'b0;
      ld_state    = 1'b0;
      laf_state   = 1'b0;
      full_state  = 1'b0;
      lfd_state   = 1'b0;
      rst_int_reg = 1'b0;
   endtask

   task automatic do_header(input logic [7:0] h);
      clr_ctl();
      detect_addr = 1'b1;
      pkt_valid   = 1'b1;
      din         = h;
      step();
      check_eq("hdr_pay_cnt_clr", {10'd0, pay_cnt}, 16'd0);
      check_eq("hdr_pd_clr", {15'd0, parity_done}, 16'd0);
      check_eq("hdr_err_clr", {15'd0, err}, 16'd0);
      check_eq("hdr_len_err_clr", {15'd0, len_err}, 16'd0);
   endtask

   task automatic do_lfd(input logic [7:0] exp_h);
      clr_ctl();
      lfd_state = 1'b1;
      pkt_valid = 1'b1;
      exp_q.push_back(exp_h);
      step();
      check_dout("lfd_dout");
   endtask

   task automatic do_byte(input logic [7:0] b);
      clr_ctl();
      ld_state  = 1'b1;
      pkt_valid = 1'b1;
      din       = b;
      exp_q.push_back(b);
      step();
      check_dout("pay_dout");
   endtask

   task automatic do_check(input logic [7:0] c);
      clr_ctl();
      ld_state = 1'b1;
      din      = c;
      exp_q.push_back(c);
      step();
      check_dout("chk_dout");
   endtask

   task automatic do_idle();
      clr_ctl();
      step();
   endtask

   task automatic run_pkt(input logic [7:0] h, input int n, input logic [7:0] c,
                          input logic e_err, input logic e_err_s, input logic e_len);
      do_header(h);
      do_lfd(h);
      for (int i = 0; i < n; i++) do_byte(pay[i]);
      check_eq("pkt_pay_cnt", {10'd0, pay_cnt}, 16'(n));
      do_check(c);
      check_eq("pkt_pd", {15'd0, parity_done}, 16'd1);
      check_eq("pkt_low_pv", {15'd0, low_pkt_valid}, 16'd1);
      check_eq("pkt_pay_cnt_chk", {10'd0, pay_cnt}, 16'(n));
      do_idle();
      check_eq("pkt_err", {15'd0, err}, {15'd0, e_err});
      check_eq("pkt_err_sum", {15'd0, err_s}, {15'd0, e_err_s});
      check_eq("pkt_len_err", {15'd0, len_err}, {15'd0, e_len});
      check_eq("pkt_len_err_sum", {15'd0, len_err_s}, {15'd0, e_len});
      do_idle();
      check_eq("pkt_err_sticky", {15'd0, err}, {15'd0, e_err});
      clr_ctl();
      rst_int_reg = 1'b1;
      step();
      check_eq("pkt_low_pv_clr", {15'd0, low_pkt_valid}, 16'd0);
   endtask

   initial begin
      pay[0] = 8'h24; pay[1] = 8'h81; pay[2] = 8'h09; pay[3] = 8'h63; pay[4] = 8'h0D;
      clr_ctl();

      // reset with random inputs
      rst         = 1'b0;
      pkt_valid   = 1'($urandom_range(0, 1));
      din         = 8'($urandom_range(0, 255));
      fifo_full   = 1'($urandom_range(0, 1));
      detect_addr = 1'($urandom_range(0, 1));
      ld_state    = 1'($urandom_range(0, 1));
      laf_state   = 1'($urandom_range(0, 1));
      full_state  = 1'($urandom_range(0, 1));
      lfd_state   = 1'($urandom_range(0, 1));
      rst_int_reg = 1'($urandom_range(0, 1));
      step();
      check_eq("rst_dout", {8'd0, dout}, 16'd0);
      check_eq("rst_dout_sum", {8'd0, dout_s}, 16'd0);
      check_eq("rst_err", {15'd0, err}, 16'd0);
      check_eq("rst_len_err", {15'd0, len_err}, 16'd0);
      check_eq("rst_pd", {15'd0, parity_done}, 16'd0);
      check_eq("rst_pd_sum", {15'd0, parity_done_s}, 16'd0);
      check_eq("rst_low_pv", {15'd0, low_pkt_valid}, 16'd0);
      check_eq("rst_low_pv_sum", {15'd0, low_pkt_valid_s}, 16'd0);
      check_eq("rst_pay_cnt", {10'd0, pay_cnt}, 16'd0);
      check_eq("rst_pay_cnt_sum", {10'd0, pay_cnt_s}, 16'd0);
      rst = 1'b1;
      do_idle();

      // XOR check D7 is right, sum check is 33
      run_pkt(8'h15, 5, 8'hD7, 1'b0, 1'b1, 1'b0);
      run_pkt(8'h15, 5, 8'h46, 1'b1, 1'b1, 1'b0);
      run_pkt(8'h15, 5, 8'h33, 1'b1, 1'b0, 1'b0);
      // short packet: XOR of header+4 bytes = DA
      run_pkt(8'h15, 4, 8'hDA, 1'b0, 1'b1, 1'b1);

      // invalid address (addr=3) must not replace the header
      do_header(8'h2B);
      do_lfd(8'h15);

      // stall on 3rd payload byte, full_state cycle, then load-after-full
      do_header(8'h15);
      do_lfd(8'h15);
      do_byte(8'h24);
      do_byte(8'h81);
      clr_ctl();
      ld_state = 1'b1; pkt_valid = 1'b1; fifo_full = 1'b1; din = 8'h09;
      step();
      check_eq("stall_dout_hold", {8'd0, dout}, 16'h0081);
      check_eq("stall_pay_cnt", {10'd0, pay_cnt}, 16'd3);
      clr_ctl();
      full_state = 1'b1; ld_state = 1'b1; pkt_valid = 1'b1; fifo_full = 1'b1; din = 8'h09;
      step();
      check_eq("full_dout_hold", {8'd0, dout}, 16'h0081);
      check_eq("full_pay_cnt", {10'd0, pay_cnt}, 16'd3);
      clr_ctl();
      laf_state = 1'b1; pkt_valid = 1'b1; din = 8'h63;
      step();
      check_eq("laf_dout_hold_reg", {8'd0, dout}, 16'h0009);
      check_eq("laf_pay_cnt", {10'd0, pay_cnt}, 16'd3);
      do_byte(8'h63);
      do_byte(8'h0D);
      do_check(8'hD7);
      do_idle();
      check_eq("stall_err", {15'd0, err}, 16'd0);
      check_eq("stall_len_err", {15'd0, len_err}, 16'd0);
      check_eq("stall_pay_cnt_end", {10'd0, pay_cnt}, 16'd5);
      check_eq("stall_low_pv", {15'd0, low_pkt_valid}, 16'd1);
      clr_ctl();
      rst_int_reg = 1'b1;
      step();
      check_eq("rir_low_pv_clr", {15'd0, low_pkt_valid}, 16'd0);

      // check byte arrives while FIFO full; parity_done comes from laf path
      do_header(8'h15);
      do_lfd(8'h15);
      for (int i = 0; i < 5; i++) do_byte(pay[i]);
      clr_ctl();
      ld_state = 1'b1; fifo_full = 1'b1; din = 8'hD7;
      step();
      check_eq("lateck_dout_hold", {8'd0, dout}, 16'h000D);
      check_eq("lateck_pd", {15'd0, parity_done}, 16'd0);
      check_eq("lateck_low_pv", {15'd0, low_pkt_valid}, 16'd1);
      clr_ctl();
      laf_state = 1'b1;
      step();
      check_eq("lateck_laf_dout", {8'd0, dout}, 16'h00D7);
      check_eq("lateck_laf_pd", {15'd0, parity_done}, 16'd1);
      do_idle();
      check_eq("lateck_err", {15'd0, err}, 16'd0);
      // rst_int_reg beats a simultaneous set
      clr_ctl();
      ld_state = 1'b1; rst_int_reg = 1'b1; din = 8'hD7;
      step();
      check_eq("rir_wins", {15'd0, low_pkt_valid}, 16'd0);

      // zero-length header, 70 payload bytes: counter saturates, len_err set
      do_header(8'h01);
      do_lfd(8'h01);
      for (int i = 0; i < 70; i++) do_byte(8'h00);
      check_eq("sat_pay_cnt", {10'd0, pay_cnt}, 16'd63);
      do_check(8'h01);
      do_idle();
      check_eq("sat_len_err", {15'd0, len_err}, 16'd1);
      check_eq("sat_err", {15'd0, err}, 16'd0);
      check_eq("sat_err_sum", {15'd0, err_s}, 16'd0);

      // reset in the middle of a packet
      do_header(8'h15);
      do_lfd(8'h15);
      do_byte(8'h24);
      do_byte(8'h81);
      clr_ctl();
      rst = 1'b0; ld_state = 1'b1; pkt_valid = 1'b1; din = 8'h09;
      step();
      check_eq("midrst_dout", {8'd0, dout}, 16'd0);
      check_eq("midrst_pay_cnt", {10'd0, pay_cnt}, 16'd0);
      check_eq("midrst_low_pv", {15'd0, low_pkt_valid}, 16'd0);
      check_eq("midrst_pd", {15'd0, parity_done}, 16'd0);
      check_eq("midrst_err", {15'd0, err}, 16'd0);
      check_eq("midrst_len_err", {15'd0, len_err}, 16'd0);
      rst = 1'b1;
      do_idle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
